// File: rtl/buf_load_wr_if.sv
// Bundle of the command, beat-stream and row-write signals of the GEMM buffer loader.
// The master side issues commands and beats; the slave side (the loader) drives the row writes.
interface buf_load_wr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROW_WIDTH  = 128,
  parameter int ADR_WIDTH  = 32,
  parameter int IDX_WIDTH  = 12
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADR_WIDTH-1:0]  cmd_base;
  logic [IDX_WIDTH-1:0]  cmd_rows;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  mem_wr_en;
  logic [ADR_WIDTH-1:0]  mem_wr_addr;
  logic [ROW_WIDTH-1:0]  mem_wr_data;

  modport master (
    output cmd_valid, cmd_base, cmd_rows, s_valid, s_data,
    input  cmd_ready, s_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_rows, s_valid, s_data,
    output cmd_ready, s_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/buf_load_wr.sv
// Write-side loader for the GEMM input/weight buffers: packs narrow beats into full rows
// and issues one single-cycle write per row at base + row*ADDR_STRIDE.
module buf_load_wr #(
  parameter int DATA_WIDTH  = 32,
  parameter int ROW_WIDTH   = 128,
  parameter int ADR_WIDTH   = 32,
  parameter int IDX_WIDTH   = 12,
  parameter int ADDR_STRIDE = 16
) (
  input  logic           clk,
  input  logic           rst,
  buf_load_wr_if.slave   bus,
  output logic           busy,
  output logic           done
);

  localparam int BEATS = ROW_WIDTH / DATA_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state;
  logic [ADR_WIDTH-1:0] base_q;
  logic [IDX_WIDTH-1:0] rows_q;
  logic [IDX_WIDTH-1:0] row_cnt;
  logic [BW-1:0]        beat_cnt;
  logic [ROW_WIDTH-1:0] row_q;
  logic [ROW_WIDTH-1:0] row_next;
  logic                 wr_en_q;
  logic [ADR_WIDTH-1:0] wr_addr_q;
  logic [ROW_WIDTH-1:0] wr_data_q;
  logic                 done_q;
  logic                 beat_fire;
  logic                 last_beat;
  logic                 last_row;
  logic [ADR_WIDTH-1:0] row_addr;

  assign beat_fire = (state == S_FILL) && bus.s_valid;
  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign last_row  = (row_cnt == rows_q - IDX_WIDTH'(1));
  assign row_addr  = base_q + ADR_WIDTH'(row_cnt) * ADR_WIDTH'(ADDR_STRIDE);

  // The row with the current beat merged in, so the last beat goes straight into the write register.
  always_comb begin
    row_next = row_q;
    if (beat_fire) begin
      row_next[int'(beat_cnt) * DATA_WIDTH +: DATA_WIDTH] = bus.s_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      base_q    <= '0;
      rows_q    <= '0;
      row_cnt   <= '0;
      beat_cnt  <= '0;
      row_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            base_q   <= bus.cmd_base;
            rows_q   <= bus.cmd_rows;
            row_cnt  <= '0;
            beat_cnt <= '0;
            if (bus.cmd_rows == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state <= S_FILL;
            end
          end
        end
        S_FILL: begin
          if (beat_fire) begin
            row_q <= row_next;
            if (last_beat) begin
              beat_cnt  <= '0;
              wr_en_q   <= 1'b1;
              wr_addr_q <= row_addr;
              wr_data_q <= row_next;
              state     <= S_WRITE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (last_row) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            row_cnt <= row_cnt + 1'b1;
            state   <= S_FILL;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = (state == S_IDLE);
  assign bus.s_ready     = (state == S_FILL);
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_addr = wr_addr_q;
  assign bus.mem_wr_data = wr_data_q;
  assign busy            = (state != S_IDLE);
  assign done            = done_q;

endmodule

// File: tb/tb_buf_load_wr.sv
// Directed bench for buf_load_wr: a 128-bit/stride-16 instance for most scenarios and a
// 2048-bit/stride-128 instance for the wide-row address wrap case.
module tb_buf_load_wr;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, done, wbusy, wdone;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int sready_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  buf_load_wr_if #(.DATA_WIDTH(32), .ROW_WIDTH(128), .ADR_WIDTH(32), .IDX_WIDTH(12)) bif ();
  buf_load_wr_if #(.DATA_WIDTH(32), .ROW_WIDTH(2048), .ADR_WIDTH(32), .IDX_WIDTH(12)) wif ();

  buf_load_wr #(.DATA_WIDTH(32), .ROW_WIDTH(128), .ADR_WIDTH(32), .IDX_WIDTH(12), .ADDR_STRIDE(16)) dut (
    .clk(clk), .rst(rst), .bus(bif.slave), .busy(busy), .done(done)
  );

  buf_load_wr #(.DATA_WIDTH(32), .ROW_WIDTH(2048), .ADR_WIDTH(32), .IDX_WIDTH(12), .ADDR_STRIDE(128)) dut_w (
    .clk(clk), .rst(rst), .bus(wif.slave), .busy(wbusy), .done(wdone)
  );

  logic [31:0]   wa_q[$];
  logic [127:0]  wd_q[$];
  int            wc_q[$];
  int            dc_q[$];
  logic [31:0]   wwa_q[$];
  logic [2047:0] wwd_q[$];
  logic [31:0]   beat_q[$];
  int last_acc, cmd_cyc, idle_cyc;

  // Record every row write and done pulse mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bif.mem_wr_en) begin
      wa_q.push_back(bif.mem_wr_addr);
      wd_q.push_back(bif.mem_wr_data);
      wc_q.push_back(cycle);
    end
    if (done) dc_q.push_back(cycle);
    if ((bif.mem_wr_en || done) && bif.s_ready) sready_bad <= sready_bad + 1;
    if (wif.mem_wr_en) begin
      wwa_q.push_back(wif.mem_wr_addr);
      wwd_q.push_back(wif.mem_wr_data);
    end
  end

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); dc_q.delete();
    wwa_q.delete(); wwd_q.delete();
  endtask

  task automatic send_cmd(input logic [31:0] base, input logic [11:0] rows);
    int g = 0;
    bif.cmd_valid = 1'b1; bif.cmd_base = base; bif.cmd_rows = rows;
    while (!bif.cmd_ready && g < 50) begin @(posedge clk); #1; g++; end
    checks++;
    if (bif.cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL cmd_accept: cmd_ready=%b required 1", bif.cmd_ready);
    end
    cmd_cyc = cycle;
    @(posedge clk); #1;
    bif.cmd_valid = 1'b0;
  endtask

  task automatic drive_stream(input bit bubbles);
    int idx = 0;
    int g = 0;
    bit take;
    while (idx < beat_q.size() && g < 2000) begin
      if (bubbles && $urandom_range(0, 2) == 0) bif.s_valid = 1'b0;
      else begin bif.s_valid = 1'b1; bif.s_data = beat_q[idx]; end
      take = bif.s_valid && bif.s_ready;
      if (take) last_acc = cycle;
      @(posedge clk); #1; g++;
      if (take) idx++;
    end
    bif.s_valid = 1'b0;
    checks++;
    if (idx != beat_q.size()) begin
      errors++; $display("[TB] FAIL stream_accept: beats taken=%0d required %0d", idx, beat_q.size());
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!bif.cmd_ready && g < 50) begin @(posedge clk); #1; g++; end
    idle_cyc = cycle;
    checks++;
    if (bif.cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL idle_timeout: cmd_ready=%b required 1", bif.cmd_ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({bif.cmd_ready, bif.s_ready, busy, done, bif.mem_wr_en} !== 5'b10000) begin
      errors++; $display("[TB] FAIL reset_ctrl: rdy/srdy/busy/done/wr=%b required 10000",
                         {bif.cmd_ready, bif.s_ready, busy, done, bif.mem_wr_en});
    end
    checks++;
    if (bif.mem_wr_addr !== 32'h0 || bif.mem_wr_data !== 128'h0) begin
      errors++; $display("[TB] FAIL reset_bus: addr=%h data=%h required 0", bif.mem_wr_addr, bif.mem_wr_data);
    end
    checks++;
    if (wbusy !== 1'b0 || wif.cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_wide: busy=%b cmd_ready=%b required 0/1", wbusy, wif.cmd_ready);
    end
  endtask

  task automatic test_single_row();
    clear_mon();
    beat_q = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    send_cmd(32'h0, 12'd1);
    drive_stream(1'b0);
    wait_idle();
    checks++;
    if (wa_q.size() != 1 || dc_q.size() != 1) begin
      errors++; $display("[TB] FAIL single_counts: writes=%0d dones=%0d required 1/1", wa_q.size(), dc_q.size());
    end
    checks++;
    if (wa_q[0] !== 32'h0 || wd_q[0] !== 128'h0F0E0D0C_0B0A0908_07060504_03020100) begin
      errors++; $display("[TB] FAIL single_row: addr=%h data=%h required 0/0f0e..0100", wa_q[0], wd_q[0]);
    end
    checks++;
    if (wc_q[0] != last_acc + 1 || dc_q[0] != last_acc + 2 || idle_cyc != last_acc + 3) begin
      errors++; $display("[TB] FAIL single_timing: wr=%0d done=%0d idle=%0d required %0d/%0d/%0d",
                         wc_q[0], dc_q[0], idle_cyc, last_acc + 1, last_acc + 2, last_acc + 3);
    end
  endtask

  task automatic test_multi_row(input bit bubbles);
    logic [127:0] exp;
    clear_mon();
    beat_q.delete();
    for (int k = 0; k < 12; k++) beat_q.push_back(32'hA000_0000 + 32'(k));
    sready_bad = 0;
    send_cmd(32'h20, 12'd3);
    drive_stream(bubbles);
    wait_idle();
    checks++;
    if (wa_q.size() != 3 || dc_q.size() != 1) begin
      errors++; $display("[TB] FAIL multi_counts(bub=%0d): writes=%0d dones=%0d required 3/1",
                         bubbles, wa_q.size(), dc_q.size());
    end
    for (int r = 0; r < 3; r++) begin
      exp = {beat_q[4*r+3], beat_q[4*r+2], beat_q[4*r+1], beat_q[4*r]};
      checks++;
      if (wa_q[r] !== 32'h20 + 32'(r) * 32'h10 || wd_q[r] !== exp) begin
        errors++; $display("[TB] FAIL multi_row%0d(bub=%0d): addr=%h data=%h required %h/%h",
                           r, bubbles, wa_q[r], wd_q[r], 32'h20 + 32'(r) * 32'h10, exp);
      end
    end
    checks++;
    if (dc_q[0] != wc_q[2] + 1) begin
      errors++; $display("[TB] FAIL multi_done(bub=%0d): done=%0d required %0d", bubbles, dc_q[0], wc_q[2] + 1);
    end
    if (!bubbles) begin
      checks++;
      if (wc_q[1] - wc_q[0] != 5 || wc_q[2] - wc_q[1] != 5) begin
        errors++; $display("[TB] FAIL back_to_back_spacing: gaps=%0d,%0d required 5,5",
                           wc_q[1] - wc_q[0], wc_q[2] - wc_q[1]);
      end
    end
    checks++;
    if (sready_bad != 0) begin
      errors++; $display("[TB] FAIL sready_in_write_done: count=%0d required 0", sready_bad);
    end
  endtask

  task automatic test_zero_rows();
    clear_mon();
    send_cmd(32'h40, 12'd0);
    wait_idle();
    checks++;
    if (wa_q.size() != 0 || dc_q.size() != 1) begin
      errors++; $display("[TB] FAIL zero_counts: writes=%0d dones=%0d required 0/1", wa_q.size(), dc_q.size());
    end
    checks++;
    if (dc_q[0] != cmd_cyc + 1 || idle_cyc != cmd_cyc + 2) begin
      errors++; $display("[TB] FAIL zero_timing: done=%0d idle=%0d required %0d/%0d",
                         dc_q[0], idle_cyc, cmd_cyc + 1, cmd_cyc + 2);
    end
  endtask

  task automatic test_mid_reset();
    clear_mon();
    beat_q = '{32'hDEAD_0000, 32'hDEAD_0001};
    send_cmd(32'h80, 12'd1);
    drive_stream(1'b0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bif.cmd_ready, bif.s_ready, busy, done, bif.mem_wr_en} !== 5'b10000 ||
        bif.mem_wr_addr !== 32'h0 || bif.mem_wr_data !== 128'h0) begin
      errors++; $display("[TB] FAIL midreset_outputs: ctrl=%b addr=%h data=%h required 10000/0/0",
                         {bif.cmd_ready, bif.s_ready, busy, done, bif.mem_wr_en}, bif.mem_wr_addr, bif.mem_wr_data);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    beat_q = '{32'h5555_0000, 32'h5555_0001, 32'h5555_0002, 32'h5555_0003};
    send_cmd(32'h100, 12'd1);
    drive_stream(1'b0);
    wait_idle();
    checks++;
    if (wa_q.size() != 1) begin
      errors++; $display("[TB] FAIL midreset_writes: writes=%0d required 1", wa_q.size());
    end
    checks++;
    if (wa_q[0] !== 32'h100 || wd_q[0] !== 128'h5555_0003_5555_0002_5555_0001_5555_0000) begin
      errors++; $display("[TB] FAIL midreset_row: addr=%h data=%h required 100/55550003..55550000", wa_q[0], wd_q[0]);
    end
  endtask

  task automatic test_addr_wrap();
    clear_mon();
    beat_q.delete();
    for (int k = 0; k < 8; k++) beat_q.push_back(32'hC000_0000 + 32'(k));
    send_cmd(32'hFFFF_FFF0, 12'd2);
    drive_stream(1'b0);
    wait_idle();
    checks++;
    if (wa_q.size() != 2 || wa_q[0] !== 32'hFFFF_FFF0 || wa_q[1] !== 32'h0) begin
      errors++; $display("[TB] FAIL wrap_addr: n=%0d a0=%h a1=%h required 2/fffffff0/00000000",
                         wa_q.size(), wa_q[0], wa_q[1]);
    end
  endtask

  task automatic test_wide_wrap();
    logic [2047:0] exp;
    int n = 0;
    int g = 0;
    bit take;
    clear_mon();
    wif.cmd_valid = 1'b1; wif.cmd_base = 32'hFFFF_FF80; wif.cmd_rows = 12'd2;
    @(posedge clk); #1;
    wif.cmd_valid = 1'b0;
    while (n < 128 && g < 1000) begin
      wif.s_valid = 1'b1; wif.s_data = 32'h5A00_0000 + 32'(n);
      take = wif.s_ready;
      @(posedge clk); #1; g++;
      if (take) n++;
    end
    wif.s_valid = 1'b0;
    g = 0;
    while (!wif.cmd_ready && g < 50) begin @(posedge clk); #1; g++; end
    checks++;
    if (n != 128 || wif.cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL wide_stream: beats=%0d cmd_ready=%b required 128/1", n, wif.cmd_ready);
    end
    checks++;
    if (wwa_q.size() != 2 || wwa_q[0] !== 32'hFFFF_FF80 || wwa_q[1] !== 32'h0) begin
      errors++; $display("[TB] FAIL wide_addr: n=%0d a0=%h a1=%h required 2/ffffff80/00000000",
                         wwa_q.size(), wwa_q[0], wwa_q[1]);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 64; i++) exp[i*32 +: 32] = 32'h5A00_0000 + 32'(r * 64 + i);
      checks++;
      if (wwd_q[r] !== exp) begin
        errors++; $display("[TB] FAIL wide_row%0d: lanes0-1=%h required %h", r, wwd_q[r][63:0], exp[63:0]);
      end
    end
  endtask

  initial begin
    bif.cmd_valid = 1'b0; bif.cmd_base = '0; bif.cmd_rows = '0; bif.s_valid = 1'b0; bif.s_data = '0;
    wif.cmd_valid = 1'b0; wif.cmd_base = '0; wif.cmd_rows = '0; wif.s_valid = 1'b0; wif.s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    test_single_row();
    test_multi_row(1'b0);
    test_multi_row(1'b1);
    test_zero_rows();
    test_mid_reset();
    test_addr_wrap();
    test_wide_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
